sm_add_serial: RTL and testbench

Bit-serial sign-magnitude adder, the addition counterpart of the team's combinational sign-magnitude subtractor. Takes two N-bit sign-magnitude operands (MSB = sign, low N-1 bits = magnitude) through a valid/ready handshake. Processes the magnitude one bit per clock, LSB first, and returns a sign-magnitude sum with a magnitude carry flag. It sits in the arithmetic datapath where area matters more than throughput.

---
 rtl/sm_pkg.sv | 34 +++
 rtl/sm_bit_cell.sv | 27 ++
 rtl/sm_add_serial.sv | 173 +++++++++++++++++
 tb/tb_sm_add_serial.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// Shared types and helpers for the bit-serial sign-magnitude adder.
// Holds the FSM state enum, the default operand width, the counter-width
// derivation and sign/magnitude field helpers.
package sm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default total operand width (sign + magnitude).
    localparam int unsigned SM_N = 8;

    // Bit counter must index magnitude bits 0..N-2.
    function automatic int unsigned sm_cnt_w(input int unsigned n);
        return $clog2(n - 1);
    endfunction

    localparam int unsigned SM_CNT_W = sm_cnt_w(SM_N);

    // Sign bit of an n-bit sign-magnitude value held in the low bits of v.
    function automatic logic sm_sign(input logic [31:0] v, input int unsigned n);
        return 1'(v >> (n - 1));
    endfunction

    // Magnitude field (low n-1 bits) of an n-bit sign-magnitude value.
    function automatic logic [31:0] sm_mag(input logic [31:0] v, input int unsigned n);
        logic [31:0] mask;
        mask = (32'd1 << (n - 1)) - 32'd1;
        return v & mask;
    endfunction

endpackage

// File: rtl/sm_bit_cell.sv
// One-bit full adder / subtractor used by the serial datapath.
// i_sub=0: o_r = x+y+c, o_c_out = carry.
// i_sub=1: o_r = x-y-c, o_c_out = borrow.
module sm_bit_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_c_in,
    input  logic i_sub,
    output logic o_r,
    output logic o_c_out
);

    logic w_xy;

    assign w_xy = i_x ^ i_y;

    // Result bit is identical for add and subtract; only the carry/borrow differs.
    always_comb begin
        o_r = w_xy ^ i_c_in;
        if (i_sub) begin
            o_c_out = (~i_x & i_y) | (~w_xy & i_c_in);
        end else begin
            o_c_out = (i_x & i_y) | (w_xy & i_c_in);
        end
    end

endmodule

// File: rtl/sm_add_serial.sv
// Bit-serial sign-magnitude adder: one magnitude bit per clock, LSB first.
// Optional subtract mode (A-B) selected by i_op when SM_ADD_SUB_EN is defined.
//
// Handshake: an input transfer happens on a rising edge where o_ready and
// i_valid are both high; an output transfer happens on a rising edge where
// o_valid and i_ready are both high. o_ready is high only in IDLE, o_valid
// only in DONE, and o_out/o_carry stay stable for the whole DONE interval.
module sm_add_serial
    import sm_pkg::*;
#(
    parameter int unsigned N = SM_N
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [N-1:0] o_out,
    output logic         o_carry,
    output logic         o_valid,
    input  logic         i_ready,
`ifdef SM_ADD_SUB_EN
    input  logic         i_op,
`endif
    output logic [1:0]   o_state
);

    localparam int unsigned M  = N - 1;
    localparam int unsigned CW = sm_cnt_w(N);

    state_t         r_state;
    state_t         w_next_state;
    logic           w_accept;
    logic           w_last;

    logic [M-1:0]   r_x;
    logic [M-1:0]   r_y;
    logic [M-1:0]   r_mag;
    logic [CW-1:0]  r_cnt;
    logic           r_c;
    logic           r_eff_sub;
    logic           r_sign;
    logic [N-1:0]   r_out;
    logic           r_carry;

    logic [31:0]    w_a_ext;
    logic [31:0]    w_b_ext;
    logic [M-1:0]   w_a_mag;
    logic [M-1:0]   w_b_mag;
    logic           w_sign_a;
    logic           w_sign_b;
    logic           w_sign_b_eff;
    logic           w_eff_sub;
    logic           w_swap;

    logic           w_r;
    logic           w_c_out;
    logic [M-1:0]   w_mag_next;
    logic           w_carry_final;
    logic           w_sign_final;

    // Operand field decode for the accept cycle.
    assign w_a_ext  = 32'(i_a);
    assign w_b_ext  = 32'(i_b);
    assign w_a_mag  = M'(sm_mag(w_a_ext, N));
    assign w_b_mag  = M'(sm_mag(w_b_ext, N));
    assign w_sign_a = sm_sign(w_a_ext, N);
    assign w_sign_b = sm_sign(w_b_ext, N);

`ifdef SM_ADD_SUB_EN
    assign w_sign_b_eff = w_sign_b ^ i_op;
`else
    assign w_sign_b_eff = w_sign_b;
`endif

    // Differing signs mean a magnitude subtraction; always subtract the smaller.
    assign w_eff_sub = w_sign_a ^ w_sign_b_eff;
    assign w_swap    = w_eff_sub && (w_b_mag > w_a_mag);

    sm_bit_cell u_cell (
        .i_x     (r_x[0]),
        .i_y     (r_y[0]),
        .i_c_in  (r_c),
        .i_sub   (r_eff_sub),
        .o_r     (w_r),
        .o_c_out (w_c_out)
    );

    // Result bits enter at the top so bit 0 lands at the LSB after M shifts.
    assign w_mag_next    = {w_r, r_mag[M-1:1]};
    assign w_carry_final = ~r_eff_sub & w_c_out;
    // Zero magnitude without carry is always reported as +0.
    assign w_sign_final  = r_sign & ((|w_mag_next) | w_carry_final);

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (r_cnt == CW'(N - 2)) begin
                    w_last       = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Serial datapath: latch operands at accept, then one bit per RUN edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_mag     <= '0;
            r_cnt     <= '0;
            r_c       <= 1'b0;
            r_eff_sub <= 1'b0;
            r_sign    <= 1'b0;
            r_out     <= '0;
            r_carry   <= 1'b0;
        end else if (w_accept) begin
            r_x       <= w_swap ? w_b_mag : w_a_mag;
            r_y       <= w_swap ? w_a_mag : w_b_mag;
            r_mag     <= '0;
            r_cnt     <= '0;
            r_c       <= 1'b0;
            r_eff_sub <= w_eff_sub;
            r_sign    <= w_swap ? w_sign_b_eff : w_sign_a;
        end else if (r_state == RUN) begin
            r_x   <= r_x >> 1;
            r_y   <= r_y >> 1;
            r_c   <= w_c_out;
            r_cnt <= r_cnt + CW'(1);
            r_mag <= w_mag_next;
            if (w_last) begin
                r_out   <= {w_sign_final, w_mag_next};
                r_carry <= w_carry_final;
            end
        end
    end

    assign o_out   = r_out;
    assign o_carry = r_carry;
    assign o_state = r_state;

endmodule

// File: tb/tb_sm_add_serial.sv
// Self-checking bench for sm_add_serial (define SM_ADD_SUB_EN to cover A-B).
module tb_sm_add_serial;

    localparam int N = 8;
    localparam int M = N - 1;

    // Clock and reset
    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] o_out;
    logic         o_carry;
    logic         o_valid;
    logic         i_ready;
    logic [1:0]   o_state;
`ifdef SM_ADD_SUB_EN
    logic         i_op;
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    always #5 clk = ~clk;

    sm_add_serial #(.N(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_out   (o_out),
        .o_carry (o_carry),
        .o_valid (o_valid),
        .i_ready (i_ready),
`ifdef SM_ADD_SUB_EN
        .i_op    (i_op),
`endif
        .o_state (o_state)
    );

    // Scoreboard
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [N:0]   exp_q[$];   // {carry, sign, magnitude}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: signed-magnitude arithmetic on plain integers.
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic op);
        int ma, mb, s, mag;
        bit sa, sb, sign, carry;
        ma = int'(a[N-2:0]);
        mb = int'(b[N-2:0]);
        sa = a[N-1];
        sb = b[N-1] ^ (op & HAS_SUB);
        if (sa == sb) begin
            s     = ma + mb;
            mag   = s % (1 << M);
            carry = (s >= (1 << M));
            sign  = sa;
        end else begin
            carry = 1'b0;
            if (ma >= mb) begin
                mag  = ma - mb;
                sign = sa;
            end else begin
                mag  = mb - ma;
                sign = sb;
            end
        end
        if (mag == 0 && !carry) sign = 1'b0;
        return {carry, sign, M'(mag)};
    endfunction

    task automatic set_op(input logic op);
`ifdef SM_ADD_SUB_EN
        i_op = op;
`else
        if (op) $display("note: i_op ignored in add-only build");
`endif
    endtask

    // Driver: one full transaction with hold cycles of backpressure in DONE.
    task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic op, input int hold);
        int         guard;
        int         cyc;
        logic [N:0] exp;
        guard = 0;
        while (!o_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!o_ready) begin
            check("ready_timeout", 32'(o_ready), 32'(1));
            return;
        end
        i_a = a;
        i_b = b;
        set_op(op);
        i_valid = 1'b1;
        exp_q.push_back(model(a, b, op));
        @(posedge clk); #1;
        // Scramble inputs after accept; they must have no effect.
        i_a = N'($urandom);
        i_b = N'($urandom);
        set_op(HAS_SUB & 1'($urandom));
        i_valid = 1'b0;
        check("ready_low_run", 32'(o_ready), 32'(0));
        cyc = 0;
        while (!o_valid && cyc < 50) begin
            i_valid = 1'($urandom);
            i_ready = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        i_ready = 1'b0;
        check("latency", 32'(cyc), 32'(N - 1));
        exp = exp_q.pop_front();
        check("out", 32'(o_out), 32'(exp[N-1:0]));
        check("carry", 32'(o_carry), 32'(exp[N]));
        check("ready_low_done", 32'(o_ready), 32'(0));
        for (int h = 0; h < hold; h++) begin
            i_valid = 1'b1;
            i_a = N'($urandom);
            i_b = N'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 32'(o_valid), 32'(1));
            check("hold_data", 32'({o_carry, o_out}), 32'({exp[N], exp[N-1:0]}));
            check("hold_ready", 32'(o_ready), 32'(0));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check("rel_valid", 32'(o_valid), 32'(0));
        check("rel_ready", 32'(o_ready), 32'(1));
        check("out_held", 32'(o_out), 32'(exp[N-1:0]));
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Stimulus and final report
    initial begin
        rst = 1'b1;
        i_a = '0;
        i_b = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        set_op(1'b0);
        #1;
        check("rst_ready", 32'(o_ready), 32'(1));
        check("rst_valid", 32'(o_valid), 32'(0));
        check("rst_out", 32'(o_out), 32'(0));
        check("rst_carry", 32'(o_carry), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed cases
        run_txn(8'h05, 8'h03, 1'b0, 0);
        run_txn(8'h85, 8'h03, 1'b0, 0);
        run_txn(8'h03, 8'h85, 1'b0, 0);
        run_txn(8'h07, 8'h87, 1'b0, 0);
        run_txn(8'h64, 8'h64, 1'b0, 0);
        run_txn(8'hC0, 8'hC0, 1'b0, 0);
        run_txn(8'h80, 8'h00, 1'b0, 0);
        run_txn(8'h7F, 8'h7F, 1'b0, 0);
        run_txn(8'h12, 8'h34, 1'b0, 5);
        if (HAS_SUB) begin
            run_txn(8'h05, 8'h03, 1'b1, 0);
            run_txn(8'h03, 8'h05, 1'b1, 0);
            run_txn(8'h85, 8'h83, 1'b1, 0);
        end

        // Reset during RUN at bit 3
        i_a = 8'h55;
        i_b = 8'h2A;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", 32'(o_ready), 32'(1));
        check("midrst_valid", 32'(o_valid), 32'(0));
        check("midrst_out", 32'(o_out), 32'(0));
        check("midrst_carry", 32'(o_carry), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (N + 2) begin
            @(posedge clk); #1;
            check("post_rst_no_valid", 32'(o_valid), 32'(0));
        end
        run_txn(8'h21, 8'h0F, 1'b0, 0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            run_txn(N'($urandom), N'($urandom), HAS_SUB & 1'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
